scoreboard_counter: RTL and testbench
=====================================

Name: scoreboard_counter

Overview:
Multi-channel, single-clock successor to the dual-clock up/down score counter; one channel per team score. Each channel takes raw up/down/clear button levels, synchronises and edge-detects them internally, and counts within [0, MAX_VAL]. The mode is saturating or wrap-around, with optional hold-to-repeat. Outputs per channel are the binary count, BCD tens/ones digits for the 7-segment driver, and limit flags.

Parameters:
CH, 2, number of independent counter channels (1..4)
BW, 7, count width in bits; 2^BW-1 >= MAX_VAL
MAX_VAL, 99, upper count limit (1..99, BCD-representable)
WRAP, 0, 0 = saturate at 0/MAX_VAL, 1 = wrap MAX_VAL<->0
RPT_EN, 1, 1 = auto-repeat while a button is held
HOLD_CYC, 8000000, cycles a button must be held before the first repeat
RPT_CYC, 2000000, cycles between subsequent repeats

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-low
up_i  in  CH  raw count-up button level, bit c = channel c (asynchronous)
down_i  in  CH  raw count-down button level (asynchronous)
clr_i  in  CH  raw clear button level (asynchronous)
cnt_o  out  CH*BW  binary count, channel c at [c*BW +: BW]
tens_o  out  CH*4  BCD tens digit, channel c at [c*4 +: 4]
ones_o  out  CH*4  BCD ones digit, channel c at [c*4 +: 4]
at_max_o  out  CH  1 when the channel count == MAX_VAL
at_min_o  out  CH  1 when the channel count == 0

Behaviour:
- Reset (rst_i low at a clock edge): all counts, BCD digits, synchroniser flops, edge-detect flops and hold timers clear to 0. Outputs: cnt_o=0, tens_o=0, ones_o=0, at_max_o=0, at_min_o=all 1. Reset mid-hold aborts the repeat; the first repeat after release of reset requires a fresh press.
- Input path per bit: 2-flop synchroniser, then a previous-value flop; press pulse = sync & ~prev.
- Latency: input high before edge E1 -> cnt_o/BCD change after edge E3. All outputs are registered and flags are consistent with cnt_o in the same cycle.
- Step request per channel per cycle: inc = up press or up repeat tick; dec = down press or down repeat tick.
- Priority per channel: clear press > (inc & dec -> no change) > inc > dec.
- inc at MAX_VAL: WRAP=0 hold at MAX_VAL; WRAP=1 go to 0. dec at 0: WRAP=0 hold at 0; WRAP=1 go to MAX_VAL.
- BCD digits are maintained as parallel digit counters, not by division. Required invariant every cycle: tens*10+ones == cnt. On ones 9->0 with inc, tens increments; on ones 0->9 with dec, tens decrements. Wrap sets the digits directly.
- Hold/repeat FSM per channel (RPT_EN=1): states IDLE, HOLD, REPEAT.
  - IDLE -> HOLD on a press of exactly one of up/down (synced level); timer loads 0.
  - HOLD: timer counts each cycle. At timer == HOLD_CYC-1, emit one repeat tick in the held direction and go to REPEAT with timer 0.
  - REPEAT: emit a tick every RPT_CYC cycles.
  - Any state -> IDLE when the held level drops, both up and down are high, or clear is pressed.
  - Timer width is $clog2(max(HOLD_CYC, RPT_CYC)+1).
- RPT_EN=0: FSM and timers are absent and only press pulses count.
- Channels are fully independent; no cross-channel interaction.
- Parameter legality (MAX_VAL <= 99, MAX_VAL < 2^BW, 1 <= CH <= 4) is checked by a generate-time error.

Test Plan:
1. Reset, then ch0 up_i held 3 cycles and released, repeated 5x -> cnt_o[ch0]=5, tens=0, ones=5; ch1 stays 0, at_min_o[1]=1. Latency measured as exactly 3 edges.
2. MAX_VAL=99, WRAP=0: 101 up presses -> cnt stays at 99 and at_max_o=1. Then 100 down presses -> cnt 0 and at_min_o=1; BCD invariant checked every cycle.
3. WRAP=1: one down press from 0 -> cnt 99, tens=9, ones=9. One up press -> 0. Boundary 9->10 and 10->9 checked for correct digit carry/borrow.
4. up_i and down_i rising on the same cycle -> no change. Clear pressed with up on the same cycle from 42 -> 0.
5. RPT_EN=1, HOLD_CYC=10, RPT_CYC=4: up held 30 cycles from 0 -> one press plus repeats at hold cycles 10, 14, 18, 22, 26 -> final 6. Release, then re-hold -> timer restarts.
6. Reset asserted for 1 cycle mid-REPEAT at count 17 -> outputs 0 on the next cycle. Button still held after reset -> no count until release and re-press.

Source files
------------

// File: rtl/scoreboard_counter.sv
// Multi-channel score counter: synchronised, edge-detected buttons with
// saturate or wrap counting, optional hold-to-repeat, and parallel BCD digits.
module scoreboard_counter #(
  parameter int CH       = 2,
  parameter int BW       = 7,
  parameter int MAX_VAL  = 99,
  parameter int WRAP     = 0,
  parameter int RPT_EN   = 1,
  parameter int HOLD_CYC = 8000000,
  parameter int RPT_CYC  = 2000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CH-1:0]    up_i,
  input  logic [CH-1:0]    down_i,
  input  logic [CH-1:0]    clr_i,
  output logic [CH*BW-1:0] cnt_o,
  output logic [CH*4-1:0]  tens_o,
  output logic [CH*4-1:0]  ones_o,
  output logic [CH-1:0]    at_max_o,
  output logic [CH-1:0]    at_min_o
);

  localparam int MAX_T = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam int NB    = 3 * CH;
  localparam logic [BW-1:0] MAX_CNT  = BW'(MAX_VAL);
  localparam logic [3:0]    MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0]    MAX_ONES = 4'(MAX_VAL % 10);

  if ((CH < 1) || (CH > 4) || (MAX_VAL < 1) || (MAX_VAL > 99) || (MAX_VAL >= (1 << BW))) begin : g_bad_param
    $error("scoreboard_counter: illegal CH/BW/MAX_VAL combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;

  logic [NB-1:0] raw_s, sync1_r, sync2_r, prev_r, arm_r, press_s;
  logic [1:0]    settle_r;

  assign raw_s = {clr_i, down_i, up_i};
  // arm_r blocks a button still held through reset until it has been seen released
  assign press_s = sync2_r & ~prev_r & arm_r;

  // synchroniser, edge-detect history and post-reset arming
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      prev_r   <= '0;
      arm_r    <= '0;
      settle_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      arm_r   <= arm_r | ({NB{settle_r[1]}} & ~sync2_r);
      if (settle_r != 2'b11) settle_r <= settle_r + 2'b01;
      else                   settle_r <= settle_r;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic up_l, dn_l, up_p, dn_p, clr_p, inc_s, dec_s;
    logic [BW-1:0] cnt_r, cnt_s;
    logic [3:0]    tens_r, tens_s, ones_r, ones_s;
    logic          max_r, min_r;

    assign up_l  = sync2_r[c];
    assign dn_l  = sync2_r[CH + c];
    assign up_p  = press_s[c];
    assign dn_p  = press_s[CH + c];
    assign clr_p = press_s[2*CH + c];

    if (RPT_EN != 0) begin : g_rpt
      state_t        state_r, state_s;
      logic [TW-1:0] timer_r, timer_s;
      logic          dir_r, dir_s, tick_s, abort_s;

      // dir_r: 1 = holding up, 0 = holding down
      assign abort_s = clr_p | (up_l & dn_l) | (dir_r ? ~up_l : ~dn_l);
      assign inc_s   = up_p | (tick_s & dir_r);
      assign dec_s   = dn_p | (tick_s & ~dir_r);

      // hold/repeat next-state and tick generation
      always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        dir_s   = dir_r;
        tick_s  = 1'b0;
        case (state_r)
          IDLE: begin
            timer_s = '0;
            if (!clr_p && up_p && !dn_l) begin
              state_s = HOLD;
              dir_s   = 1'b1;
            end else if (!clr_p && dn_p && !up_l) begin
              state_s = HOLD;
              dir_s   = 1'b0;
            end else begin
              state_s = IDLE;
            end
          end
          HOLD, REPEAT: begin
            if (abort_s) begin
              state_s = IDLE;
              timer_s = '0;
            end else if (timer_r == ((state_r == HOLD) ? TW'(HOLD_CYC - 1) : TW'(RPT_CYC - 1))) begin
              tick_s  = 1'b1;
              state_s = REPEAT;
              timer_s = '0;
            end else begin
              timer_s = timer_r + TW'(1);
            end
          end
          default: begin
            state_s = IDLE;
            timer_s = '0;
          end
        endcase
      end

      // hold/repeat state registers
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          state_r <= IDLE;
          timer_r <= '0;
          dir_r   <= 1'b0;
        end else begin
          state_r <= state_s;
          timer_r <= timer_s;
          dir_r   <= dir_s;
        end
      end
    end else begin : g_norpt
      assign inc_s = up_p;
      assign dec_s = dn_p;
    end

    // next count and digits; digits step alongside the binary count
    always_comb begin
      cnt_s  = cnt_r;
      tens_s = tens_r;
      ones_s = ones_r;
      if (clr_p) begin
        cnt_s  = '0;
        tens_s = 4'd0;
        ones_s = 4'd0;
      end else if (inc_s && !dec_s) begin
        if (cnt_r == MAX_CNT) begin
          if (WRAP != 0) begin
            cnt_s  = '0;
            tens_s = 4'd0;
            ones_s = 4'd0;
          end else begin
            cnt_s = cnt_r;
          end
        end else if (ones_r == 4'd9) begin
          cnt_s  = cnt_r + BW'(1);
          ones_s = 4'd0;
          tens_s = tens_r + 4'd1;
        end else begin
          cnt_s  = cnt_r + BW'(1);
          ones_s = ones_r + 4'd1;
        end
      end else if (dec_s && !inc_s) begin
        if (cnt_r == '0) begin
          if (WRAP != 0) begin
            cnt_s  = MAX_CNT;
            tens_s = MAX_TENS;
            ones_s = MAX_ONES;
          end else begin
            cnt_s = cnt_r;
          end
        end else if (ones_r == 4'd0) begin
          cnt_s  = cnt_r - BW'(1);
          ones_s = 4'd9;
          tens_s = tens_r - 4'd1;
        end else begin
          cnt_s  = cnt_r - BW'(1);
          ones_s = ones_r - 4'd1;
        end
      end else begin
        cnt_s = cnt_r;
      end
    end

    // registered count, digits and limit flags
    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        cnt_r  <= '0;
        tens_r <= 4'd0;
        ones_r <= 4'd0;
        max_r  <= 1'b0;
        min_r  <= 1'b1;
      end else begin
        cnt_r  <= cnt_s;
        tens_r <= tens_s;
        ones_r <= ones_s;
        max_r  <= (cnt_s == MAX_CNT);
        min_r  <= (cnt_s == '0);
      end
    end

    assign cnt_o[c*BW +: BW] = cnt_r;
    assign tens_o[c*4 +: 4]  = tens_r;
    assign ones_o[c*4 +: 4]  = ones_r;
    assign at_max_o[c]       = max_r;
    assign at_min_o[c]       = min_r;
  end

endmodule

// File: tb/tb_scoreboard_counter.sv
// Bench for scoreboard_counter: saturating and wrapping instances share stimulus,
// checked by vector table, directed sequences and a per-cycle reference model.
module tb_scoreboard_counter;

  localparam int MAXV = 99;
  localparam int HOLD = 10;
  localparam int RPT  = 4;

  logic        clk, rst;
  logic [1:0]  up, dn, clr;
  logic [13:0] cnt0, cnt1;
  logic [7:0]  tens0, tens1, ones0, ones1;
  logic [1:0]  amax0, amax1, amin0, amin1;

  int n_chk  = 0;
  int n_fail = 0;

  scoreboard_counter #(.CH(2), .BW(7), .MAX_VAL(MAXV), .WRAP(0), .RPT_EN(1),
                       .HOLD_CYC(HOLD), .RPT_CYC(RPT)) dut0 (
    .clk_i(clk), .rst_i(rst), .up_i(up), .down_i(dn), .clr_i(clr),
    .cnt_o(cnt0), .tens_o(tens0), .ones_o(ones0), .at_max_o(amax0), .at_min_o(amin0));

  scoreboard_counter #(.CH(2), .BW(7), .MAX_VAL(MAXV), .WRAP(1), .RPT_EN(1),
                       .HOLD_CYC(HOLD), .RPT_CYC(RPT)) dut1 (
    .clk_i(clk), .rst_i(rst), .up_i(up), .down_i(dn), .clr_i(clr),
    .cnt_o(cnt1), .tens_o(tens1), .ones_o(ones1), .at_max_o(amax1), .at_min_o(amin1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: button pipeline shared, counting state per [wrap][channel]
  int m_r1[3][2], m_lvl[3][2], m_prev[3][2], m_arm[3][2];
  int m_since;
  int m_act[2][2], m_dir[2][2], m_k[2][2], m_cnt[2][2];

  function automatic int raw_bit(int b, int c);
    if (b == 0) return int'(up[c]);
    else if (b == 1) return int'(dn[c]);
    else return int'(clr[c]);
  endfunction

  task automatic model_edge();
    int p[3][2];
    int ab, tk, inc, dec;
    if (!rst) begin
      m_since = 0;
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 2; c++) begin
          m_r1[b][c] = 0; m_lvl[b][c] = 0; m_prev[b][c] = 0; m_arm[b][c] = 0;
        end
      for (int w = 0; w < 2; w++)
        for (int c = 0; c < 2; c++) begin
          m_act[w][c] = 0; m_dir[w][c] = 0; m_k[w][c] = 0; m_cnt[w][c] = 0;
        end
    end else begin
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 2; c++)
          p[b][c] = (m_lvl[b][c] != 0 && m_prev[b][c] == 0 && m_arm[b][c] != 0) ? 1 : 0;
      for (int w = 0; w < 2; w++)
        for (int c = 0; c < 2; c++) begin
          ab = (p[2][c] != 0 || (m_lvl[0][c] != 0 && m_lvl[1][c] != 0) ||
                (m_act[w][c] != 0 && m_lvl[m_dir[w][c]][c] == 0)) ? 1 : 0;
          tk = (m_act[w][c] != 0 && ab == 0 &&
                (m_k[w][c] == HOLD || (m_k[w][c] > HOLD && (m_k[w][c] - HOLD) % RPT == 0))) ? 1 : 0;
          inc = (p[0][c] != 0 || (tk != 0 && m_dir[w][c] == 0)) ? 1 : 0;
          dec = (p[1][c] != 0 || (tk != 0 && m_dir[w][c] == 1)) ? 1 : 0;
          if (p[2][c] != 0) m_cnt[w][c] = 0;
          else if (inc != 0 && dec == 0)
            m_cnt[w][c] = (m_cnt[w][c] == MAXV) ? ((w != 0) ? 0 : MAXV) : m_cnt[w][c] + 1;
          else if (dec != 0 && inc == 0)
            m_cnt[w][c] = (m_cnt[w][c] == 0) ? ((w != 0) ? MAXV : 0) : m_cnt[w][c] - 1;
          if (m_act[w][c] != 0) begin
            if (ab != 0) m_act[w][c] = 0;
            else m_k[w][c] = m_k[w][c] + 1;
          end else if (p[2][c] == 0 && p[0][c] != 0 && m_lvl[1][c] == 0) begin
            m_act[w][c] = 1; m_dir[w][c] = 0; m_k[w][c] = 1;
          end else if (p[2][c] == 0 && p[1][c] != 0 && m_lvl[0][c] == 0) begin
            m_act[w][c] = 1; m_dir[w][c] = 1; m_k[w][c] = 1;
          end
        end
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 2; c++) begin
          if (m_since >= 2 && m_lvl[b][c] == 0) m_arm[b][c] = 1;
          m_prev[b][c] = m_lvl[b][c];
          m_lvl[b][c]  = m_r1[b][c];
          m_r1[b][c]   = raw_bit(b, c);
        end
      if (m_since < 3) m_since = m_since + 1;
    end
  endtask

  task automatic check_model();
    logic [33:0] act, exp;
    logic [13:0] ec;
    logic [7:0]  et, eo;
    logic [1:0]  emx, emn;
    for (int w = 0; w < 2; w++) begin
      for (int c = 0; c < 2; c++) begin
        ec[c*7 +: 7] = 7'(m_cnt[w][c]);
        et[c*4 +: 4] = 4'(m_cnt[w][c] / 10);
        eo[c*4 +: 4] = 4'(m_cnt[w][c] % 10);
        emx[c] = (m_cnt[w][c] == MAXV);
        emn[c] = (m_cnt[w][c] == 0);
      end
      exp = {ec, et, eo, emx, emn};
      act = (w != 0) ? {cnt1, tens1, ones1, amax1, amin1} : {cnt0, tens0, ones0, amax0, amin0};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_wrap%0d t=%0t got cnt=%h tens=%h ones=%h max=%b min=%b want cnt=%h tens=%h ones=%h max=%b min=%b",
                 w, $time, act[33:20], act[19:12], act[11:4], act[3:2], act[1:0], ec, et, eo, emx, emn);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    n_chk++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, actual, expected);
    end
  endtask

  task automatic apply_op(input logic [1:0] u, input logic [1:0] d, input logic [1:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      up = u; dn = d; clr = k;
      repeat (3) cyc();
      up = 2'b00; dn = 2'b00; clr = 2'b00;
      repeat (4) cyc();
    end
  endtask

  typedef struct {
    logic [1:0] u, d, k;
    int n;
    int e00, e01, e10, e11;  // expected count [wrap][channel]
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{2'b01, 2'b00, 2'b00,   5,  5, 0,  5,  0};
    tbl[1]  = '{2'b00, 2'b10, 2'b00,   1,  5, 0,  5, 99};
    tbl[2]  = '{2'b10, 2'b00, 2'b00,   1,  5, 1,  5,  0};
    tbl[3]  = '{2'b01, 2'b00, 2'b00,   5, 10, 1, 10,  0};
    tbl[4]  = '{2'b00, 2'b01, 2'b00,   1,  9, 1,  9,  0};
    tbl[5]  = '{2'b11, 2'b11, 2'b00,   1,  9, 1,  9,  0};
    tbl[6]  = '{2'b00, 2'b00, 2'b01,   1,  0, 1,  0,  0};
    tbl[7]  = '{2'b01, 2'b00, 2'b00,  42, 42, 1, 42,  0};
    tbl[8]  = '{2'b01, 2'b00, 2'b01,   1,  0, 1,  0,  0};
    tbl[9]  = '{2'b00, 2'b01, 2'b00,   1,  0, 1, 99,  0};
    tbl[10] = '{2'b01, 2'b00, 2'b00,   1,  1, 1,  0,  0};
    tbl[11] = '{2'b00, 2'b00, 2'b11,   1,  0, 0,  0,  0};
    tbl[12] = '{2'b01, 2'b00, 2'b00, 101, 99, 0,  1,  0};
    tbl[13] = '{2'b00, 2'b01, 2'b00, 100,  0, 0,  1,  0};

    rst = 1'b0; up = 2'b00; dn = 2'b00; clr = 2'b00;
    repeat (3) cyc();
    chk("reset_cnt0", int'(cnt0), 0);
    chk("reset_min0", int'(amin0), 3);
    chk("reset_max1", int'(amax1), 0);
    rst = 1'b1;
    repeat (5) cyc();

    // latency: level applied before E1 shows after E3
    up = 2'b01;
    cyc(); cyc();
    chk("latency_e2", int'(cnt0[6:0]), 0);
    cyc();
    chk("latency_e3", int'(cnt0[6:0]), 1);
    up = 2'b00;
    repeat (4) cyc();
    apply_op(2'b00, 2'b00, 2'b11, 1);

    foreach (tbl[i]) begin
      apply_op(tbl[i].u, tbl[i].d, tbl[i].k, tbl[i].n);
      chk($sformatf("vec%0d_w0c0", i), int'(cnt0[6:0]),  tbl[i].e00);
      chk($sformatf("vec%0d_w0c1", i), int'(cnt0[13:7]), tbl[i].e01);
      chk($sformatf("vec%0d_w1c0", i), int'(cnt1[6:0]),  tbl[i].e10);
      chk($sformatf("vec%0d_w1c1", i), int'(cnt1[13:7]), tbl[i].e11);
      if (i == 12) chk("sat_at_max", int'(amax0[0]), 1);
      if (i == 13) chk("sat_at_min", int'(amin0[0]), 1);
    end

    // hold-to-repeat: 30 held cycles -> press + 5 repeats, then fresh hold
    apply_op(2'b00, 2'b00, 2'b11, 1);
    up = 2'b01;
    repeat (30) cyc();
    up = 2'b00;
    repeat (6) cyc();
    chk("hold30_w0", int'(cnt0[6:0]), 6);
    chk("hold30_w1", int'(cnt1[6:0]), 6);
    up = 2'b01;
    repeat (12) cyc();
    up = 2'b00;
    repeat (6) cyc();
    chk("rehold12_w0", int'(cnt0[6:0]), 8);

    // reset in mid-repeat with the button still held
    apply_op(2'b00, 2'b00, 2'b11, 1);
    up = 2'b01;
    for (int i = 0; i < 200 && m_cnt[0][0] != 17; i++) cyc();
    chk("reach17", int'(cnt0[6:0]), 17);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("midrpt_rst_cnt", int'(cnt0[6:0]), 0);
    chk("midrpt_rst_min", int'(amin1), 3);
    repeat (20) cyc();
    chk("held_after_rst", int'(cnt0[6:0]), 0);
    up = 2'b00;
    repeat (5) cyc();
    apply_op(2'b01, 2'b00, 2'b00, 1);
    chk("repress_after_rst", int'(cnt0[6:0]), 1);

    // randomised levels, occasional clears and resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) up = up ^ (2'b01 << $urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) dn = dn ^ (2'b01 << $urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst = 1'b1; up = 2'b00; dn = 2'b00; clr = 2'b00;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
